cache_backing_mem: RTL

CACHE_BACKING_MEM -- requirements
Module: cache_backing_mem

---
 rtl/cache_backing_mem.sv | 92 +++++++++
 1 files changed

// File: rtl/cache_backing_mem.sv
// Block-granular backing memory for a cache: one read or masked write per request, committed LATENCY edges after accept.
// mem_ready drops for LATENCY cycles per operation; requests seen while busy are ignored, not queued.
module cache_backing_mem #(
  parameter int WORD_W      = 10,
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 2,
  parameter int LATENCY     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_req,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             address,
  input  logic [WORD_W*BLOCK_WORDS-1:0] wdata,
  input  logic [BLOCK_WORDS-1:0]        wmask,
  output logic [WORD_W*BLOCK_WORDS-1:0] rdata,
  output logic                          rvalid,
  output logic                          mem_ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BLK_W = WORD_W * BLOCK_WORDS;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state;
  logic [3:0]               cnt;
  logic                     op_we;
  logic [ADDR_W-1:0]        op_base;
  logic [BLK_W-1:0]         op_wdata;
  logic [BLOCK_WORDS-1:0]   op_wmask;
  logic                     commit;

  // Contents are not covered by reset; they start at zero and survive rst.
  logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

  assign commit = (state == BUSY) && (cnt == 4'd1) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_ready <= 1'b1;
      rvalid    <= 1'b0;
      rdata     <= '0;
      op_we     <= 1'b0;
      op_base   <= '0;
      op_wdata  <= '0;
      op_wmask  <= '0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            op_we     <= we;
            op_base   <= address & ~ADDR_W'(BLOCK_WORDS - 1);
            op_wdata  <= wdata;
            op_wmask  <= wmask;
            cnt       <= 4'(LATENCY);
            mem_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= IDLE;
            mem_ready <= 1'b1;
            if (!op_we) begin
              for (int k = 0; k < BLOCK_WORDS; k++) begin
                rdata[k*WORD_W +: WORD_W] <= mem[op_base | ADDR_W'(k)];
              end
              rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit && op_we) begin
      for (int k = 0; k < BLOCK_WORDS; k++) begin
        if (op_wmask[k]) begin
          mem[op_base | ADDR_W'(k)] <= op_wdata[k*WORD_W +: WORD_W];
        end
      end
    end
  end

endmodule
